pipeline_debug_controller: RTL
==============================

Name: pipeline_debug_controller

Overview:
Sequences the MIPS pipeline (IF/ID/EX/MEM/WB) from a byte-stream host link.
- Loads program words into instruction memory.
- Runs the pipeline continuously until halt, or for one clock (single step).
- After each run or step, streams the PC, the cycle count and all 32 registers back as bytes.
- Sits between the UART rx/tx byte interfaces and the pipeline top; owns the pipeline's global enable.

Parameters:
N_BITS, 32, datapath word width
N_REG_BITS, 5, register-file address width (2^N_REG_BITS registers dumped)
IMEM_ADDR_BITS, 8, instruction-memory word-address width

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  tx byte pending
i_tx_ready  in  1  transmitter accepts byte (transfer = o_tx_valid & i_tx_ready)
o_imem_we  out  1  instruction-memory write strobe
o_imem_addr  out  IMEM_ADDR_BITS  instruction-memory word address
o_imem_data  out  N_BITS  instruction word to write
o_pipe_enable  out  1  pipeline clock enable (all stage registers)
i_halt  in  1  HALT instruction reached WB
i_pc  in  N_BITS  current PC
o_reg_addr  out  N_REG_BITS  register-file debug read address
i_reg_data  in  N_BITS  combinational read data for o_reg_addr
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async): state=IDLE. All outputs 0; cycle counter 0; load address 0.
- Every output is registered.
- Commands, accepted only in IDLE; any other byte is ignored:
  - 0x4C 'L' -> LOAD_CNT
  - 0x43 'C' -> RUN
  - 0x53 'S' -> STEP
- LOAD_CNT: next rx byte is N, the word count; N=0 means 256. Clear the cycle counter and the write address, then go to LOAD.
- LOAD:
  - Collect 4 bytes per word, least-significant byte first.
  - The edge after the 4th byte drives o_imem_we=1 for exactly one cycle, with o_imem_addr = current word index and o_imem_data = assembled word.
  - Then increment the address; it wraps modulo 2^IMEM_ADDR_BITS.
  - After N words, return to IDLE.
- RUN:
  - Entry edge sets o_pipe_enable=1.
  - At each edge in RUN: if i_halt=1, set enable<=0 and go to DUMP; otherwise stay.
  - At least one enabled cycle always occurs, even if i_halt is already high on entry.
- STEP: o_pipe_enable=1 for exactly one cycle, then DUMP.
- Cycle counter: N_BITS wide, increments on every cycle with o_pipe_enable=1, wraps at 2^N_BITS.
- DUMP:
  - Sends 4-byte words, LSB first, in this order: PC (sampled on DUMP entry), cycle counter, then reg[0]..reg[2^N_REG_BITS-1].
  - With defaults this is 136 bytes.
  - o_reg_addr holds the register index; i_reg_data is sampled when that word's first byte is loaded.
  - o_tx_data and o_tx_valid are held stable until the transfer cycle.
  - The next byte is presented on the following edge; at most one byte per two cycles is acceptable.
  - After the last transfer: o_tx_valid=0, go to IDLE.
- During LOAD, RUN, STEP and DUMP, rx bytes not consumed by the protocol are dropped.
- Reset mid-operation: immediate return to IDLE; o_pipe_enable and o_imem_we drop asynchronously; partial words are discarded.

Optional Feature:
DEBUG_ABORT_EN.
- Defined: in RUN, rx byte 0x41 'A' forces enable<=0 and a transition to DUMP on the same edge as a halt would. If 'A' and i_halt arrive together, the result is a single DUMP.
- Undefined: the pipeline stops only on i_halt; a RUN that never halts hangs until reset.

Test Plan:
- Load 'L',0x02, bytes 24 18 22 00, 25 18 22 00 -> two we pulses: addr0=0x00221824, addr1=0x00221825; state IDLE; o_busy=0.
- 'S' after reset, i_pc=0x4, reg[k]=k -> exactly 1 enable cycle, then 136 bytes: 04 00 00 00, 01 00 00 00, 00 00 00 00, 01 00 00 00 ... 1F 00 00 00.
- 'C', i_halt raised after 10 enabled cycles -> enable high 11 cycles; cycle-count field in dump = 11.
- Hold i_tx_ready=0 for 50 cycles mid-dump -> o_tx_data/o_tx_valid stable, no byte lost or duplicated; total 136 transfers.
- i_reset asserted during LOAD after 2 bytes, then 'L',0x01 + 4 bytes -> single write at addr 0 with only the new bytes.
- With DEBUG_ABORT_EN: 'C' with i_halt=0, then 'A' -> enable falls the next edge, dump follows; without the macro, 'A' is ignored and enable stays 1.

Source files
------------

// File: rtl/pipeline_debug_controller.sv
// pipeline_debug_controller
// Host-link sequencer for the 5-stage MIPS pipeline: loads instruction words
// from the rx byte stream, runs or single-steps the pipeline through its
// global enable, then streams PC, cycle count and the register file back
// over tx, least-significant byte first.
// Optional macro DEBUG_ABORT_EN: an 'A' byte received during RUN stops the
// pipeline and starts the dump, exactly as a halt would.
module pipeline_debug_controller #(
    parameter int N_BITS         = 32,
    parameter int N_REG_BITS     = 5,
    parameter int IMEM_ADDR_BITS = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [7:0]                i_rx_data,
    input  logic                      i_rx_valid,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic                      o_imem_we,
    output logic [IMEM_ADDR_BITS-1:0] o_imem_addr,
    output logic [N_BITS-1:0]         o_imem_data,
    output logic                      o_pipe_enable,
    input  logic                      i_halt,
    input  logic [N_BITS-1:0]         i_pc,
    output logic [N_REG_BITS-1:0]     o_reg_addr,
    input  logic [N_BITS-1:0]         i_reg_data,
    output logic                      o_busy
);

    localparam int BYTES   = N_BITS / 8;
    localparam int BIDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int N_WORDS = 2 + (1 << N_REG_BITS);   // PC, cycles, registers
    localparam int WIDX_W  = N_REG_BITS + 2;
    localparam int CNT_W   = 9;                        // word count 1..256

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h43;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_ABORT = 8'h41;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CNT,
        S_LOAD,
        S_RUN,
        S_STEP,
        S_DUMP
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [7:0]                r_tx_data;
    logic                      r_tx_valid;
    logic                      r_imem_we;
    logic [IMEM_ADDR_BITS-1:0] r_imem_addr;
    logic [N_BITS-1:0]         r_imem_data;
    logic                      r_pipe_en;
    logic [N_REG_BITS-1:0]     r_reg_addr;
    logic                      r_busy;

    logic [N_BITS-1:0]         r_cycle;      // enabled-cycle counter
    logic [IMEM_ADDR_BITS-1:0] r_waddr;      // next instruction word to write
    logic [CNT_W-1:0]          r_words_left;
    logic [BIDX_W-1:0]         r_byte_idx;   // byte position within load word
    logic [N_BITS-1:0]         r_asm;        // load word being assembled
    logic [N_BITS-1:0]         r_pc;         // PC captured on dump entry
    logic [WIDX_W-1:0]         r_dump_word;
    logic [BIDX_W-1:0]         r_dump_byte;
    logic [N_BITS-1:0]         r_shift;      // remaining bytes of dump word

    logic                      w_abort;
    logic                      w_load_last_byte;
    logic                      w_dump_last;
    logic                      w_tx_xfer;
    logic [N_BITS-1:0]         w_word_sel;
    logic [N_BITS-1:0]         w_load_word;

`ifdef DEBUG_ABORT_EN
    assign w_abort = (r_state == S_RUN) && i_rx_valid && (i_rx_data == CMD_ABORT);
`else
    assign w_abort = 1'b0;
`endif

    assign w_load_last_byte = (r_byte_idx == BIDX_W'(BYTES - 1));
    assign w_dump_last      = (r_dump_word == WIDX_W'(N_WORDS - 1)) &&
                              (r_dump_byte == BIDX_W'(BYTES - 1));
    assign w_tx_xfer        = r_tx_valid && i_tx_ready;
    assign w_load_word      = {i_rx_data, r_asm[N_BITS-1:8]};

    // Source of the dump word whose first byte is about to be presented
    always_comb begin
        w_word_sel = i_reg_data;
        if (r_dump_word == WIDX_W'(0))
            w_word_sel = r_pc;
        else if (r_dump_word == WIDX_W'(1))
            w_word_sel = r_cycle;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD)      w_state_nxt = S_LOAD_CNT;
                    else if (i_rx_data == CMD_RUN)  w_state_nxt = S_RUN;
                    else if (i_rx_data == CMD_STEP) w_state_nxt = S_STEP;
                end
            end
            S_LOAD_CNT: if (i_rx_valid) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (i_rx_valid && w_load_last_byte && (r_words_left == CNT_W'(1)))
                    w_state_nxt = S_IDLE;
            end
            S_RUN:  if (i_halt || w_abort) w_state_nxt = S_DUMP;
            S_STEP: w_state_nxt = S_DUMP;
            S_DUMP: if (w_tx_xfer && w_dump_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_data  <= '0;
            r_pipe_en    <= 1'b0;
            r_reg_addr   <= '0;
            r_busy       <= 1'b0;
            r_cycle      <= '0;
            r_waddr      <= '0;
            r_words_left <= '0;
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_pc         <= '0;
            r_dump_word  <= '0;
            r_dump_byte  <= '0;
            r_shift      <= '0;
        end else begin
            r_imem_we <= 1'b0;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (r_pipe_en)
                r_cycle <= r_cycle + N_BITS'(1);

            case (r_state)
                S_IDLE: begin
                    if (i_rx_valid && (i_rx_data == CMD_RUN || i_rx_data == CMD_STEP))
                        r_pipe_en <= 1'b1;
                end
                S_LOAD_CNT: begin
                    if (i_rx_valid) begin
                        r_words_left <= (i_rx_data == 8'h00) ? CNT_W'(256)
                                                             : CNT_W'(i_rx_data);
                        r_cycle      <= '0;
                        r_waddr      <= '0;
                        r_byte_idx   <= '0;
                    end
                end
                S_LOAD: begin
                    if (i_rx_valid) begin
                        r_asm      <= w_load_word;
                        r_byte_idx <= r_byte_idx + BIDX_W'(1);
                        if (w_load_last_byte) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_waddr;
                            r_imem_data  <= w_load_word;
                            r_waddr      <= r_waddr + IMEM_ADDR_BITS'(1);
                            r_words_left <= r_words_left - CNT_W'(1);
                        end
                    end
                end
                S_RUN, S_STEP: begin
                    if (w_state_nxt == S_DUMP) begin
                        r_pipe_en   <= 1'b0;
                        r_pc        <= i_pc;
                        r_dump_word <= '0;
                        r_dump_byte <= '0;
                        r_reg_addr  <= '0;
                        r_tx_valid  <= 1'b0;
                    end
                end
                S_DUMP: begin
                    if (!r_tx_valid) begin
                        // Present the next byte; a new word is sampled on its first byte
                        r_tx_valid <= 1'b1;
                        if (r_dump_byte == BIDX_W'(0)) begin
                            r_tx_data <= w_word_sel[7:0];
                            r_shift   <= w_word_sel >> 8;
                        end else begin
                            r_tx_data <= r_shift[7:0];
                            r_shift   <= r_shift >> 8;
                        end
                    end else if (i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        if (r_dump_byte == BIDX_W'(BYTES - 1)) begin
                            r_dump_byte <= '0;
                            r_dump_word <= r_dump_word + WIDX_W'(1);
                            // Word w+1 holds register w-1; settle the address early
                            if (r_dump_word != WIDX_W'(0))
                                r_reg_addr <= N_REG_BITS'(r_dump_word - WIDX_W'(1));
                        end else begin
                            r_dump_byte <= r_dump_byte + BIDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx_data     = r_tx_data;
    assign o_tx_valid    = r_tx_valid;
    assign o_imem_we     = r_imem_we;
    assign o_imem_addr   = r_imem_addr;
    assign o_imem_data   = r_imem_data;
    assign o_pipe_enable = r_pipe_en;
    assign o_reg_addr    = r_reg_addr;
    assign o_busy        = r_busy;

endmodule
